// File: rtl/booth_mac8_pkg.sv
// Shared types and Booth radix-4 recoding helper for the booth_mac8 multiply-accumulate slice.
package booth_mac8_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef logic signed [OP_W-1:0]   op_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef struct packed {
    op_t  x;
    op_t  y;
    logic clr;
    logic last;
  } beat_t;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } bdig_t;

  // Radix-4 digit for the bit triple {y[2i+1], y[2i], y[2i-1]}
  function automatic bdig_t booth_recode(input logic [2:0] t);
    bdig_t d;
    case (t)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mac8_booth8.sv
// booth8: combinational signed 8x8 radix-4 Booth multiplier with a 16-bit two's-complement product.
module booth8
  import booth_mac8_pkg::*;
(
  input  logic signed [OP_W-1:0]   x,
  input  logic signed [OP_W-1:0]   y,
  output logic signed [PROD_W-1:0] p
);

  function automatic prod_t booth_mul(input op_t a, input op_t b);
    logic [OP_W:0] bz;
    prod_t         xs;
    prod_t         pp;
    prod_t         sum;
    bz  = {b, 1'b0};
    xs  = PROD_W'(a);
    sum = '0;
    for (int i = 0; i < OP_W / 2; i++) begin
      case (booth_recode(bz[2*i +: 3]))
        BD_P1:   pp = xs;
        BD_P2:   pp = xs <<< 1;
        BD_M1:   pp = -xs;
        BD_M2:   pp = -(xs <<< 1);
        default: pp = '0;
      endcase
      sum = sum + (pp <<< (2 * i));
    end
    return sum;
  endfunction

  assign p = booth_mul(x, y);

endmodule

// File: rtl/booth_mac8.sv
// booth_mac8: pipelined signed 8x8 multiply-accumulate; emits a group total, sticky overflow and
// beat count each time a beat tagged last retires.
module booth_mac8
  import booth_mac8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OP_W-1:0]  in_x,
  input  logic signed [OP_W-1:0]  in_y,
  input  logic                    in_clear,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        out_cnt
);

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic add_ovf(input acc_t a, input acc_t b, input acc_t s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  logic             en;
  logic             vld_p0;
  beat_t            beat_p0;
  prod_t            prod_b;
  logic             vld_p1;
  logic             clr_p1;
  logic             last_p1;
  prod_t            prod_p1;
  acc_t             acc_p2;
  logic             ovf_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             grp_done_p2;

  logic             restart;
  acc_t             base;
  acc_t             prod_ext;
  acc_t             sum;
  logic             ovf_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // A full, unaccepted result freezes the whole pipe so nothing downstream is overwritten
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage A: operand capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      beat_p0 <= '0;
    end else if (en) begin
      vld_p0  <= in_valid;
      beat_p0 <= '{x: in_x, y: in_y, clr: in_clear, last: in_last};
    end
  end

  booth8 u_booth8 (
    .x (beat_p0.x),
    .y (beat_p0.y),
    .p (prod_b)
  );

  // Stage B: registered product
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      clr_p1  <= 1'b0;
      last_p1 <= 1'b0;
      prod_p1 <= '0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      clr_p1  <= beat_p0.clr;
      last_p1 <= beat_p0.last;
      prod_p1 <= prod_b;
    end
  end

  // A closed group restarts from zero even without an explicit clear
  always_comb begin
    restart  = clr_p1 || grp_done_p2;
    base     = restart ? acc_t'(0) : acc_p2;
    prod_ext = ACC_W'(prod_p1);
    sum      = base + prod_ext;
    ovf_nxt  = (restart ? 1'b0 : ovf_p2) | add_ovf(base, prod_ext, sum);
    cnt_nxt  = sat_inc(restart ? '0 : cnt_p2);
  end

  // Stage C: accumulate
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_p2      <= '0;
      ovf_p2      <= 1'b0;
      cnt_p2      <= '0;
      grp_done_p2 <= 1'b0;
    end else if (en && vld_p1) begin
      acc_p2      <= sum;
      ovf_p2      <= ovf_nxt;
      cnt_p2      <= cnt_nxt;
      grp_done_p2 <= last_p1;
    end
  end

  // With en high a held result is being taken, so it is either replaced or retired
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (en) begin
      if (vld_p1 && last_p1) begin
        out_valid <= 1'b1;
        out_acc   <= sum;
        out_ovf   <= ovf_nxt;
        out_cnt   <= cnt_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac8.sv
// Self-checking bench for booth_mac8: directed corners plus random groups against an integer model.
module tb_booth_mac8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_clear = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b1;
  logic signed [7:0] in_x = '0;
  logic signed [7:0] in_y = '0;

  logic              in_ready, in_ready16;
  logic              out_valid, out_valid16;
  logic              out_ovf, out_ovf16;
  logic [23:0]       out_acc;
  logic [15:0]       out_acc16;
  logic [7:0]        out_cnt, out_cnt16;

  booth_mac8 #(.ACC_W(24), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_clear(in_clear), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  booth_mac8 #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_x(in_x), .in_y(in_y), .in_clear(in_clear), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .out_ovf(out_ovf16), .out_cnt(out_cnt16)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: integer group sums, wrapped to each accumulator width
  typedef struct {
    longint acc24;
    bit     ovf24;
    longint acc16;
    bit     ovf16;
    int     cnt;
  } res_t;

  res_t   expq[$];
  longint m_acc24, m_acc16;
  bit     m_ovf24, m_ovf16, m_done;
  int     m_cnt;
  int     n_expected = 0;
  int     n_out = 0;
  int     last_accept = 0;
  logic [31:0] last_acc24, last_acc16, last_cnt, last_ovf24, last_ovf16;

  function automatic longint wrapw(input longint s, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = s & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint s, input int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    return (s > hi) || (s < -hi - 1);
  endfunction

  task automatic model_reset();
    m_acc24 = 0; m_acc16 = 0; m_ovf24 = 0; m_ovf16 = 0; m_cnt = 0; m_done = 0;
    expq.delete();
  endtask

  task automatic model_beat(input int x, input int y, input bit c, input bit l);
    longint p;
    longint s;
    res_t   r;
    p = longint'(x * y);
    if (c || m_done) begin
      m_acc24 = 0; m_acc16 = 0; m_ovf24 = 0; m_ovf16 = 0; m_cnt = 0;
    end
    s = m_acc24 + p;
    if (out_of_range(s, 24)) m_ovf24 = 1;
    m_acc24 = wrapw(s, 24);
    s = m_acc16 + p;
    if (out_of_range(s, 16)) m_ovf16 = 1;
    m_acc16 = wrapw(s, 16);
    if (m_cnt < 255) m_cnt++;
    if (l) begin
      r.acc24 = m_acc24; r.ovf24 = m_ovf24; r.acc16 = m_acc16; r.ovf16 = m_ovf16; r.cnt = m_cnt;
      expq.push_back(r);
      n_expected++;
      m_done = 1;
    end else begin
      m_done = 0;
    end
  endtask

  // Inputs change 1ns after a rising edge; acceptance is judged at the falling edge before the next one
  task automatic send(input int x, input int y, input bit c, input bit l);
    bit ok;
    bit done;
    in_valid = 1'b1; in_x = 8'(x); in_y = 8'(y); in_clear = c; in_last = l;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
      if (ok) begin
        model_beat(x, y, c, l);
        last_accept = cyc;
        done = 1;
      end else if (t == 3) begin
        out_ready = 1'b1;
      end
    end
    if (!done) check("send_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_clear = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    for (int i = 0; i < 300 && n_out < target; i++) begin
      @(posedge clock); #1;
    end
    check("out_count", n_out, target);
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        res_t e;
        e = expq.pop_front();
        check("acc24", 32'(out_acc), 32'(e.acc24 & 64'hFFFFFF));
        check("ovf24", {31'b0, out_ovf}, {31'b0, e.ovf24});
        check("cnt", 32'(out_cnt), e.cnt);
        check("valid16", {31'b0, out_valid16}, 32'd1);
        check("acc16", 32'(out_acc16), 32'(e.acc16 & 64'hFFFF));
        check("ovf16", {31'b0, out_ovf16}, {31'b0, e.ovf16});
        last_acc24 = 32'(out_acc);  last_acc16 = 32'(out_acc16);
        last_cnt   = 32'(out_cnt);  last_ovf24 = {31'b0, out_ovf};
        last_ovf16 = {31'b0, out_ovf16};
        n_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_out=%0d", n_out);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [23:0] hold;

    // Reset held with a beat presented
    model_reset();
    in_valid = 1'b1; in_x = 8'sd5; in_y = 8'sd5; in_clear = 1'b1; in_last = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_acc", 32'(out_acc), 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_ovf", {31'b0, out_ovf}, 32'd0);
    idle();
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rdy_after_rst", {31'b0, in_ready}, 32'd1);
    check("rdy16_after_rst", {31'b0, in_ready16}, 32'd1);

    // Single clear+last beat, latency 2
    send(-3, 7, 1, 1);
    a0 = last_accept;
    idle();
    check("lat_edge0", {31'b0, out_valid}, 32'd0);
    @(posedge clock); #1;
    check("lat_edge1", {31'b0, out_valid}, 32'd0);
    @(posedge clock); #1;
    check("lat_edge2", {31'b0, out_valid}, 32'd1);
    check("lat_cycles", cyc - a0, 32'd2);
    wait_outs(n_expected);
    check("m3x7_acc", last_acc24, 32'h00FFFFEB);
    check("m3x7_cnt", last_cnt, 32'd1);
    check("m3x7_ovf", last_ovf24, 32'd0);

    // Four back-to-back (127,127)
    send(127, 127, 1, 0);
    a0 = last_accept;
    send(127, 127, 0, 0);
    send(127, 127, 0, 0);
    send(127, 127, 0, 1);
    idle();
    check("no_bubbles", last_accept - a0, 32'd3);
    wait_outs(n_expected);
    check("x4_acc", last_acc24, 32'h0000FC04);
    check("x4_cnt", last_cnt, 32'd4);
    check("x4_ovf", last_ovf24, 32'd0);

    // Corner operands
    send(-128, -128, 1, 1);
    idle();
    wait_outs(n_expected);
    check("m128sq", last_acc24, 32'h00004000);
    send(-128, 127, 1, 1);
    idle();
    wait_outs(n_expected);
    check("m128x127", last_acc24, 32'h00FFC080);

    // 16-bit accumulator wrap with overflow
    send(127, 127, 1, 0);
    send(127, 127, 0, 0);
    send(127, 127, 0, 1);
    idle();
    wait_outs(n_expected);
    check("w16_acc", last_acc16, 32'h0000BD03);
    check("w16_ovf", last_ovf16, 32'd1);
    check("w24_ovf", last_ovf24, 32'd0);

    // Backpressure with two groups streaming
    out_ready = 1'b0;
    fork
      begin
        send(10, -3, 1, 0);
        send(4, 4, 0, 1);
        send(-7, 9, 1, 0);
        send(2, -100, 0, 1);
        idle();
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) begin
          @(posedge clock); #1;
        end
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        hold = out_acc;
        for (int i = 0; i < 5; i++) begin
          @(posedge clock); #1;
          check("bp_hold_acc", 32'(out_acc), 32'(hold));
          check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_outs(n_expected);
    check("bp_second", last_acc24, 32'h00FFFEF9);

    // Reset mid-group
    send(3, 3, 1, 0);
    send(4, 4, 0, 0);
    idle();
    @(posedge clock); #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("midrst_quiet", {31'b0, out_valid}, 32'd0);
    end
    send(5, 5, 1, 1);
    idle();
    wait_outs(n_expected);
    check("after_rst_acc", last_acc24, 32'd25);
    check("after_rst_cnt", last_cnt, 32'd1);

    // Random groups with random backpressure and gaps
    for (int g = 0; g < 25; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             (b == 0) && ($urandom_range(0, 1) == 1), b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(posedge clock); #1;
        end
      end
    end
    idle();
    out_ready = 1'b1;
    wait_outs(n_expected);
    check("drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
